pipelined_barrel_shifter: RTL
=============================

Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the 16-bit combinational barrel shifter. It supports four shift modes: logical left, logical right, arithmetic right and rotate left. There is one register stage per shift-amount bit, and a valid/ready handshake on both sides so the block can sit in a streamed datapath between producer and consumer units. Data width and shift-amount width are generic.

Parameters:
WIDTH, 16, data width in bits; power of two, at least 4
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden
STAGES, SHW, pipeline depth; one stage per shift-amount bit; fixed equal to SHW

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  WIDTH  operand A
in_amt  in  SHW  shift amount N, 0..WIDTH-1
in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  shifted result
out_zero  out  1  out_data == 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- On rst assertion, immediately: all stage valid bits 0, all stage data/amt/op registers 0, out_valid=0, out_data=0, out_zero=1. in_ready=1 while rst is low and the pipe is empty.
- Stage k (k=0..SHW-1) conditionally shifts by 2^k when amt bit k=1; otherwise data passes unchanged. Stage k registers its result together with the remaining amt bits and op.
- SLL: vacated LSBs fill with 0.
- SRL: vacated MSBs fill with 0.
- SRA: vacated MSBs fill with the original bit WIDTH-1, carried through stages as a sign register.
- ROL: bits leaving the MSB re-enter at the LSB.
- Combinations are exact for every amt 0..WIDTH-1; amt=0 returns in_data unchanged in all modes.
- Latency: a beat accepted at edge t appears on out_* after edge t+STAGES-1, i.e. STAGES cycles, with no stall.
- Throughput: 1 beat/cycle.
- Handshake: a beat transfers on in_valid&&in_ready, and on out_valid&&out_ready.
- Stall is global: advance = !out_valid || out_ready; in_ready = advance.
- When advance=0, every stage register and out_data/out_zero hold.
- Bubbles (valid=0) propagate like data; they are not compressed.
- out_data and out_zero are stable while out_valid=1 and out_ready=0.
- Simultaneous input accept and output consume in the same cycle is legal at full rate.
- in_data/in_amt/in_op are don't-care when in_valid=0; they are not captured into valid state.
- Reset mid-operation drops all in-flight beats; nothing is emitted after release until new beats enter.
- out_zero is computed in the last stage from the registered result, never combinationally from inputs.

Decomposition:
- Package barrel_pkg: shift_op_e enum (OP_SLL, OP_SRL, OP_SRA, OP_ROL) and a stage payload struct. The struct is parametrised by width through the module; the package holds only the op enum and the localparam for the op width of 2.
- One sub-module, shift_stage: a parametrised (WIDTH, SHIFT=2^k) combinational single-distance shifter for all four ops. It is instantiated SHW times via generate, and the registers live in the top.

Test Plan:
- WIDTH=16, SLL, A=0x0001, N=0,1,3,7,15 back-to-back, out_ready=1 -> 0x0001,0x0002,0x0008,0x0080,0x8000 on consecutive cycles, first result 4 cycles after accept.
- A=0xB7BB, N=4: SRA -> 0xFB7B; SRL -> 0x0B7B; SLL -> 0x7BB0; ROL -> 0x7BBB.
- ROL A=0x040E, N=7 -> 0x0702; ROL A=0x5555, N=1 -> 0xAAAA; any op with N=0 -> A unchanged.
- SRL A=0x0015, N=5 -> out_data=0x0000, out_zero=1; N=4 -> 0x0001, out_zero=0.
- Backpressure: stream 6 beats, hold out_ready=0 once out_valid rises -> in_ready=0, out_data stable for 5 cycles. Release -> all 6 results emerge in order, none lost or duplicated.
- Assert rst asynchronously (mid-cycle) with 3 beats in flight -> out_valid=0 and out_zero=1 before the next edge. After release, no output until new input; a fresh beat returns its correct result with the same latency.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding.
package barrel_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROL = 2'd3
  } shift_op_e;

endpackage

// File: rtl/shift_stage.sv
// Single-distance shifter: moves data by SHIFT positions when en is set.
module shift_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  shift_op_e        op,
  input  logic             sign,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = data;
    if (en) begin
      case (op)
        OP_SLL:  res = data << SHIFT;
        OP_SRL:  res = data >> SHIFT;
        // sign is the original operand MSB, not this stage's input MSB
        OP_SRA:  res = {{SHIFT{sign}}, data[WIDTH-1:SHIFT]};
        OP_ROL:  res = {data[WIDTH-1-SHIFT:0], data[WIDTH-1:WIDTH-SHIFT]};
        default: res = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter, one register stage per shift-amount bit, with a
// globally stalled valid/ready handshake on input and output.
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [OP_W-1:0]          in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero
);

  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned STAGES = SHW;

  // Remaining amt bits are shifted down each stage so bit 0 always drives the shifter.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    shift_op_e        op;
    logic             sign;
  } stage_t;

  logic             advance;
  logic             vld_q [STAGES];
  stage_t           pl_q  [STAGES];
  logic             s_vin [STAGES];
  stage_t           s_in  [STAGES];
  logic [WIDTH-1:0] s_res [STAGES];
  logic             zero_q;

  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign s_vin[k] = in_valid;
      assign s_in[k]  = '{data: in_data, amt: in_amt, op: shift_op_e'(in_op),
                          sign: in_data[WIDTH-1]};
    end else begin : g_body
      assign s_vin[k] = vld_q[k-1];
      assign s_in[k]  = pl_q[k-1];
    end

    shift_stage #(
      .WIDTH(WIDTH),
      .SHIFT(1 << k)
    ) u_shift (
      .data(s_in[k].data),
      .en  (s_in[k].amt[0]),
      .op  (s_in[k].op),
      .sign(s_in[k].sign),
      .res (s_res[k])
    );

    // Payload only loads on a valid beat; bubbles advance the valid bit alone.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
        pl_q[k]  <= '0;
      end else if (advance) begin
        vld_q[k] <= s_vin[k];
        if (s_vin[k]) begin
          pl_q[k] <= '{data: s_res[k], amt: SHW'(s_in[k].amt >> 1),
                       op: s_in[k].op, sign: s_in[k].sign};
        end
      end
    end
  end

  // Zero flag registered alongside the final result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else if (advance && s_vin[STAGES-1]) begin
      zero_q <= (s_res[STAGES-1] == '0);
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_data  = pl_q[STAGES-1].data;
  assign out_zero  = zero_q;

endmodule
